// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding and constants for the audio PWM scheduler
package audio_pkg;

    // State encoding doubles as the src_sel output value.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEMOD = 2'd1,
        ST_BEEP  = 2'd2,
        ST_RAMP  = 2'd3
    } state_e;

    localparam int UNDERRUN_W = 8;

    function automatic int mid_of(input int dw);
        return 1 << (dw - 1);
    endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// rtl/audio_tick_gen.sv - programmable sample-period counter with clamped period latch
module audio_tick_gen #(
    parameter int PW             = 16,
    parameter int DEFAULT_PERIOD = 1250
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          run,
    input  logic [PW-1:0] period_i,
    output logic          tick
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] per_q, per_d;
    logic [PW-1:0] per_clamped;

    // The period is only re-sampled at a wrap or while stopped, so a new
    // period_i never shortens or stretches the period in progress.
    always_comb begin
        per_clamped = (period_i < PW'(2)) ? PW'(2) : period_i;
        tick        = run && (cnt_q == per_q - PW'(1));
        cnt_d       = cnt_q;
        per_d       = per_q;
        if (!run) begin
            cnt_d = '0;
            per_d = per_clamped;
        end else if (tick) begin
            cnt_d = '0;
            per_d = per_clamped;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q <= '0;
            per_q <= PW'(DEFAULT_PERIOD);
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/audio_pwm_sched.sv
// rtl/audio_pwm_sched.sv - sample-rate scheduler and demod/beep arbiter feeding the PWM DAC
// Optional duty ramp-down on disable: AUDIO_PWM_SCHED_RAMP_EN
module audio_pwm_sched
    import audio_pkg::*;
#(
    parameter int DW             = 14,
    parameter int PW             = 16,
    parameter int DEFAULT_PERIOD = 1250,
    parameter int BEEP_HOLD      = 4
`ifdef AUDIO_PWM_SCHED_RAMP_EN
    ,
    parameter int RAMP_STEP      = 64
`endif
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  enable_i,
    input  logic [PW-1:0]         period_i,
    input  logic                  dm_valid,
    input  logic [DW-1:0]         dm_data,
    output logic                  dm_ready,
    input  logic                  bp_valid,
    input  logic [DW-1:0]         bp_data,
    output logic                  bp_ready,
    output logic [DW-1:0]         duty,
    output logic                  sample_strobe,
    output logic                  pwm_off,
    output logic [1:0]            src_sel,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    localparam logic [DW-1:0] MID = DW'(mid_of(DW));
    localparam int HW = (BEEP_HOLD < 2) ? 1 : $clog2(BEEP_HOLD + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(BEEP_HOLD);

    state_e                  state_q, state_d;
    logic [DW-1:0]           duty_q, duty_d;
    logic                    strobe_q, strobe_d;
    logic [UNDERRUN_W-1:0]   und_q, und_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    und_inc;
    logic                    tick;
    logic                    run;

    assign run = (state_q != ST_IDLE);

    audio_tick_gen #(
        .PW             (PW),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_tick_gen (
        .clk      (clk),
        .RST      (RST),
        .run      (run),
        .period_i (period_i),
        .tick     (tick)
    );

`ifdef AUDIO_PWM_SCHED_RAMP_EN
    localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);
    logic [DW-1:0] ramp_next;

    always_comb begin
        ramp_next = MID;
        if (duty_q > MID) begin
            ramp_next = ((duty_q - MID) > STEP) ? (duty_q - STEP) : MID;
        end else if (duty_q < MID) begin
            ramp_next = ((MID - duty_q) > STEP) ? (duty_q + STEP) : MID;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        strobe_d = 1'b0;
        hold_d   = hold_q;
        und_d    = und_q;
        und_inc  = 1'b0;
        dm_ready = 1'b0;
        bp_ready = 1'b0;

        // Demod drains at the sample rate in both run states, even while a beep wins.
        if (!RST && tick && (state_q == ST_DEMOD || state_q == ST_BEEP)) begin
            dm_ready = dm_valid;
            bp_ready = bp_valid;
        end

        case (state_q)
            ST_IDLE: begin
                duty_d = MID;
                if (enable_i) state_d = ST_DEMOD;
            end
            ST_DEMOD: begin
                if (tick) begin
                    strobe_d = 1'b1;
                    if (bp_valid) begin
                        duty_d  = bp_data;
                        hold_d  = HOLD_INIT;
                        state_d = ST_BEEP;
                    end else if (dm_valid) begin
                        duty_d = dm_data;
                    end else begin
                        und_inc = 1'b1;
                    end
                end
            end
            ST_BEEP: begin
                if (tick) begin
                    strobe_d = 1'b1;
                    if (bp_valid) begin
                        duty_d = bp_data;
                        hold_d = HOLD_INIT;
                    end else begin
                        und_inc = 1'b1;
                        hold_d  = (hold_q == '0) ? '0 : hold_q - HW'(1);
                        if (hold_q <= HW'(1)) state_d = ST_DEMOD;
                    end
                end
            end
`ifdef AUDIO_PWM_SCHED_RAMP_EN
            ST_RAMP: begin
                if (tick) begin
                    strobe_d = 1'b1;
                    if (enable_i) begin
                        state_d = ST_DEMOD;
                    end else begin
                        duty_d = ramp_next;
                        if (ramp_next == MID) state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A tick coinciding with disable still completes its handshake above.
        if (!enable_i && (state_q == ST_DEMOD || state_q == ST_BEEP)) begin
`ifdef AUDIO_PWM_SCHED_RAMP_EN
            state_d = ST_RAMP;
`else
            state_d = ST_IDLE;
            duty_d  = MID;
`endif
        end

        if (und_inc && (und_q != '1)) und_d = und_q + UNDERRUN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            duty_q   <= MID;
            strobe_q <= 1'b0;
            und_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            strobe_q <= strobe_d;
            und_q    <= und_d;
            hold_q   <= hold_d;
        end
    end

    assign duty          = duty_q;
    assign sample_strobe = strobe_q;
    assign pwm_off       = (state_q == ST_IDLE);
    assign src_sel       = state_q;
    assign underrun_cnt  = und_q;

endmodule

// File: tb/tb_audio_pwm_sched.sv
// tb/tb_audio_pwm_sched.sv - randomized self-checking bench for audio_pwm_sched
module tb_audio_pwm_sched;

    localparam int MID_I = 'h2000;
    localparam int BH    = 4;
    localparam int STEP  = 64;

    logic        clk = 1'b0;
    logic        RST;
    logic        enable_i;
    logic [15:0] period_i;
    logic        dm_valid;
    logic [13:0] dm_data;
    logic        dm_ready;
    logic        bp_valid;
    logic [13:0] bp_data;
    logic        bp_ready;
    logic [13:0] duty;
    logic        sample_strobe;
    logic        pwm_off;
    logic [1:0]  src_sel;
    logic [7:0]  underrun_cnt;

    always #5 clk = ~clk;

    audio_pwm_sched dut (
        .clk           (clk),
        .RST           (RST),
        .enable_i      (enable_i),
        .period_i      (period_i),
        .dm_valid      (dm_valid),
        .dm_data       (dm_data),
        .dm_ready      (dm_ready),
        .bp_valid      (bp_valid),
        .bp_data       (bp_data),
        .bp_ready      (bp_ready),
        .duty          (duty),
        .sample_strobe (sample_strobe),
        .pwm_off       (pwm_off),
        .src_sel       (src_sel),
        .underrun_cnt  (underrun_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 demod, 2 beep, 3 ramp; left = cycles to next tick.
    int m_mode, m_left, m_per, m_duty, m_strobe, m_und, m_hold;
    bit e_dm, e_bp;
    logic a_dm, a_bp;

    function automatic int clampp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    task automatic model_clock(input bit rst, input bit en, input int pi,
                               input bit dv, input int dd, input bit bv, input int bd);
        bit tick;
        int nm;
        if (rst) begin
            m_mode = 0; m_per = 1250; m_left = 0; m_duty = MID_I;
            m_strobe = 0; m_und = 0; m_hold = 0; e_dm = 0; e_bp = 0;
            return;
        end
        tick     = (m_mode != 0) && (m_left == 1);
        e_dm     = tick && dv && (m_mode == 1 || m_mode == 2);
        e_bp     = tick && bv && (m_mode == 1 || m_mode == 2);
        m_strobe = tick;
        nm       = m_mode;
        if (m_mode == 0) begin
            m_duty = MID_I;
            if (en) begin
                nm = 1; m_per = clampp(pi); m_left = m_per;
            end
        end else begin
            if (tick) begin
                m_per = clampp(pi); m_left = m_per;
                case (m_mode)
                    1: if (bv) begin m_duty = bd; m_hold = BH; nm = 2; end
                       else if (dv) m_duty = dd;
                       else if (m_und < 255) m_und++;
                    2: if (bv) begin m_duty = bd; m_hold = BH; end
                       else begin
                           if (m_und < 255) m_und++;
                           m_hold--;
                           if (m_hold <= 0) begin m_hold = 0; nm = 1; end
                       end
                    default: if (en) nm = 1;
                       else begin
                           if (m_duty - MID_I > STEP) m_duty -= STEP;
                           else if (MID_I - m_duty > STEP) m_duty += STEP;
                           else m_duty = MID_I;
                           if (m_duty == MID_I) nm = 0;
                       end
                endcase
            end else begin
                m_left--;
            end
            if (!en && (m_mode == 1 || m_mode == 2)) begin
`ifdef AUDIO_PWM_SCHED_RAMP_EN
                nm = 3;
`else
                nm = 0; m_duty = MID_I;
`endif
            end
        end
        m_mode = nm;
    endtask

    task automatic apply(input bit rst, input bit en, input int pi,
                         input bit dv, input int dd, input bit bv, input int bd);
        @(negedge clk);
        RST = rst; enable_i = en; period_i = pi[15:0];
        dm_valid = dv; dm_data = dd[13:0]; bp_valid = bv; bp_data = bd[13:0];
        model_clock(rst, en, pi, dv, dd, bv, bd);
        #1;
        a_dm = dm_ready; a_bp = bp_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] exp_vec();
        return {14'(m_duty), 1'(m_strobe), (m_mode == 0), 2'(m_mode), 8'(m_und), e_dm, e_bp};
    endfunction

    function automatic logic [27:0] act_vec();
        return {duty, sample_strobe, pwm_off, src_sel, underrun_cnt, a_dm, a_bp};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 10, 1, 'h111, 1, 'h222);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_vec: got %h want %h", act_vec(), exp_vec());
            end
        end
        vectors++;
        if ({duty, pwm_off, sample_strobe, src_sel, underrun_cnt, a_dm, a_bp} !==
            {14'h2000, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: duty=%h off=%b stb=%b src=%0d und=%0d", duty, pwm_off,
                     sample_strobe, src_sel, underrun_cnt);
        end
    endtask

    task automatic test_first_tick();
        int first = -1;
        int nstb  = 0;
        for (int i = 0; i < 32; i++) begin
            apply(0, 1, 10, 1, 'h1234, 0, 0);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL first_tick_vec c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (sample_strobe) begin
                nstb++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (first != 10 || nstb != 3) begin
            miscompares++;
            $display("FAIL first_tick_timing: first=%0d strobes=%0d want 10/3", first, nstb);
        end
    endtask

    task automatic test_period_change();
        int t = 0, last = 0, ng = 0, g0 = 0, g1 = 0, glast = 0, guard = 0;
        while (!sample_strobe && guard < 20) begin
            apply(0, 1, 10, 1, $urandom_range(0, 16383), 0, 0);
            guard++;
        end
        vectors++;
        if (!sample_strobe) begin
            miscompares++;
            $display("FAIL period_sync: no strobe within %0d cycles", guard);
        end
        for (t = 1; t < 50; t++) begin
            apply(0, 1, (t >= 3 && t < 25) ? 4 : 1, 1, $urandom_range(0, 16383), 0, 0);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL period_vec t%0d: got %h want %h", t, act_vec(), exp_vec());
            end
            if (sample_strobe) begin
                if (ng == 0) g0 = t - last;
                if (ng == 1) g1 = t - last;
                glast = t - last;
                last  = t;
                ng++;
            end
        end
        vectors++;
        if (g0 != 10 || g1 != 4 || glast != 2) begin
            miscompares++;
            $display("FAIL period_gaps: got %0d/%0d/%0d want 10/4/2", g0, g1, glast);
        end
    endtask

    task automatic test_beep();
        int bt = 0, dmc = 0, empty = 0, guard = 0;
        bit done = 0, bv;
        for (int i = 0; i < 12; i++) apply(0, 1, 4, 1, $urandom_range(0, 16383), 0, 0);
        while (!done && guard < 200) begin
            bv = (bt < 3);
            apply(0, 1, 4, 1, $urandom_range(0, 16383), bv, 'h3FFF);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL beep_vec g%0d: got %h want %h", guard, act_vec(), exp_vec());
            end
            if (e_bp) bt++;
            if (bt > 0 && a_dm) dmc++;
            if (bt == 3 && e_bp) begin
                vectors++;
                if (duty !== 14'h3FFF || src_sel !== 2'd2) begin
                    miscompares++;
                    $display("FAIL beep_active: duty=%h src=%0d want 3fff/2", duty, src_sel);
                end
            end
            if (bt == 3 && !bv && sample_strobe) empty++;
            if (bt == 3 && src_sel == 2'd1) done = 1;
            guard++;
        end
        vectors++;
        if (!done || empty != 4 || dmc != 7) begin
            miscompares++;
            $display("FAIL beep_return: done=%b empty=%0d dm_pulses=%0d want 1/4/7", done, empty, dmc);
        end
    endtask

    task automatic test_rst_mid_beep();
        int guard = 0;
        while (src_sel != 2'd2 && guard < 20) begin
            apply(0, 1, 4, 1, 'h0100, 1, 'h0200);
            guard++;
        end
        vectors++;
        if (src_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL rst_enter_beep: src=%0d want 2", src_sel);
        end
        apply(1, 1, 4, 1, 'h0100, 1, 'h0200);
        vectors++;
        if ({duty, pwm_off, sample_strobe, src_sel, underrun_cnt, a_dm, a_bp} !==
            {14'h2000, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_beep: duty=%h off=%b stb=%b src=%0d und=%0d rdy=%b%b", duty,
                     pwm_off, sample_strobe, src_sel, underrun_cnt, a_dm, a_bp);
        end
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 4, 1, 'h0100, 1, 'h0200);
            vectors++;
            if (sample_strobe !== 1'b0 || act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rst_idle c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_underrun();
        int guard = 0, nstb = 0;
        while (!sample_strobe && guard < 10) begin
            apply(0, 1, 2, 1, 'h0ABC, 0, 0);
            guard++;
        end
        for (int i = 0; i < 600; i++) begin
            apply(0, 1, 2, 0, $urandom_range(0, 16383), 0, 0);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL underrun_vec c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (sample_strobe) nstb++;
        end
        vectors++;
        if (underrun_cnt !== 8'd255 || duty !== 14'h0ABC || nstb != 300) begin
            miscompares++;
            $display("FAIL underrun_sat: und=%0d duty=%h strobes=%0d want 255/0abc/300",
                     underrun_cnt, duty, nstb);
        end
    endtask

    task automatic test_disable();
        int guard = 0;
        while (!(sample_strobe && duty == 14'h2100) && guard < 20) begin
            apply(0, 1, 2, 1, 'h2100, 0, 0);
            guard++;
        end
        vectors++;
        if (duty !== 14'h2100) begin
            miscompares++;
            $display("FAIL disable_load: duty=%h want 2100", duty);
        end
`ifdef AUDIO_PWM_SCHED_RAMP_EN
        begin
            int nstb = 0;
            guard = 0;
            do begin
                apply(0, 0, 2, 1, 'h1000, 0, 0);
                vectors++;
                if (act_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL ramp_vec g%0d: got %h want %h", guard, act_vec(), exp_vec());
                end
                if (sample_strobe) nstb++;
                guard++;
            end while (!pwm_off && guard < 40);
            vectors++;
            if (nstb != 4 || duty !== 14'h2000 || !pwm_off) begin
                miscompares++;
                $display("FAIL ramp_done: strobes=%0d duty=%h off=%b want 4/2000/1", nstb, duty, pwm_off);
            end
        end
`else
        apply(0, 0, 2, 1, 'h1000, 0, 0);
        vectors++;
        if (duty !== 14'h2000 || pwm_off !== 1'b1 || src_sel !== 2'd0 || act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL disable_idle: got %h want %h", act_vec(), exp_vec());
        end
`endif
    endtask

    task automatic test_random();
        bit en = 1;
        int pi = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en = !en;
            if ($urandom_range(0, 49) == 0) pi = $urandom_range(0, 7);
            apply(0, en, pi, ($urandom_range(0, 3) != 0), $urandom_range(0, 16383),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 16383));
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_vec c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        RST = 1; enable_i = 0; period_i = 16'd10;
        dm_valid = 0; dm_data = '0; bp_valid = 0; bp_data = '0;
        test_reset();
        test_first_tick();
        test_period_change();
        test_beep();
        test_rst_mid_beep();
        test_underrun();
        test_disable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
